// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared widths, sweep-FSM state encoding and constants for regfile_mp.
// Revision: 1.0
`default_nettype none

package regfile_mp_pkg;

  localparam int RegBusW     = 32;
  localparam int RegAddrBusW = 5;

  localparam logic [RegBusW-1:0] ZeroWord = '0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage : regfile_mp_pkg

`default_nettype wire

// File: rtl/regfile_mp_bypass_sel.sv
// regfile_bypass_sel: finds the highest-index enabled write port matching raddr.
// Revision: 1.0
`default_nettype none

module regfile_bypass_sel
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = RegBusW,
  parameter int ADDR_W = RegAddrBusW,
  parameter int NUM_WR = 2
) (
  input  logic [NUM_WR-1:0]        we_i,
  input  logic [NUM_WR*ADDR_W-1:0] waddr_i,
  input  logic [NUM_WR*DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]        raddr_i,
  output logic                     hit_o,
  output logic [DATA_W-1:0]        data_o
);

  // Ascending scan: a later (higher-index) match overrides earlier ones.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (we_i[k] && (waddr_i[k*ADDR_W +: ADDR_W] == raddr_i)) begin
        hit_o  = 1'b1;
        data_o = wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule : regfile_bypass_sel

`default_nettype wire

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass and post-reset clearing sweep.
// Optional probe outputs under macro REGFILE_PROBE_EN. Revision: 1.0
`default_nettype none

module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RegBusW,
  parameter int ADDR_W   = RegAddrBusW,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
`ifdef REGFILE_PROBE_EN
  ,
  parameter int PROBE_A_IDX = 4,
  parameter int PROBE_B_IDX = 19
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     ready
`ifdef REGFILE_PROBE_EN
  ,
  output logic [DATA_W-1:0]        probe_a,
  output logic [DATA_W-1:0]        probe_b
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ready_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset so it can map onto RAM; the sweep clears it instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= ZeroWord[DATA_W-1:0];
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we[k] && ((ZERO_REG == 0) || (waddr[k*ADDR_W +: ADDR_W] != '0))) begin
          mem_q[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign ready = ready_q;

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic              hit;
    logic [DATA_W-1:0] byp_data;
    logic [ADDR_W-1:0] ra;

    assign ra = raddr[j*ADDR_W +: ADDR_W];

    regfile_bypass_sel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_byp (
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (ra),
      .hit_o   (hit),
      .data_o  (byp_data)
    );

    always_comb begin
      if (!ready_q || !re[j] || ((ZERO_REG != 0) && (ra == '0))) begin
        rdata[j*DATA_W +: DATA_W] = '0;
      end else if (hit) begin
        rdata[j*DATA_W +: DATA_W] = byp_data;
      end else begin
        rdata[j*DATA_W +: DATA_W] = mem_q[ra];
      end
    end
  end

`ifdef REGFILE_PROBE_EN
  localparam logic [ADDR_W-1:0] PROBE_A_ADDR = ADDR_W'(PROBE_A_IDX);
  localparam logic [ADDR_W-1:0] PROBE_B_ADDR = ADDR_W'(PROBE_B_IDX);

  assign probe_a = ready_q ? mem_q[PROBE_A_ADDR] : '0;
  assign probe_b = ready_q ? mem_q[PROBE_B_ADDR] : '0;
`endif

endmodule : regfile_mp

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default parameters).
// Revision: 1.0
`default_nettype none

module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        ready;
`ifdef REGFILE_PROBE_EN
  logic [31:0] probe_a;
  logic [31:0] probe_b;
`endif

  int n_vec;
  int n_err;

  regfile_mp dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata),
    .ready (ready)
`ifdef REGFILE_PROBE_EN
    ,
    .probe_a (probe_a),
    .probe_b (probe_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we    = 2'b00;
    waddr = '0;
    wdata = '0;
    re    = 2'b11;
    raddr = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Sweep of 32 entries: ready low after 0..31 edges, high after the 32nd.
  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst   = 1'b1;
    we    = 2'b11;
    waddr = {5'd5, 5'd5};
    wdata = {32'hCAFEF00D, 32'h0BADF00D};
    raddr = {5'd5, 5'd6};
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("init_ready", {31'd0, ready}, 32'd0);
      chk("init_rdata0", rdata[31:0], 32'd0);
      chk("init_rdata1", rdata[63:32], 32'd0);
      step();
    end
    chk("ready_after_sweep", {31'd0, ready}, 32'd1);
    we = 2'b00;
    #1;
    chk("r5_after_init", rdata[63:32], 32'h0);
    chk("r6_after_init", rdata[31:0], 32'h0);
  endtask

  task automatic test_basic();
    idle_inputs();
    we = 2'b01;
    waddr[4:0]  = 5'd3;
    wdata[31:0] = 32'hDEADBEEF;
    raddr[4:0]  = 5'd3;
    #1;
    chk("basic_bypass", rdata[31:0], 32'hDEADBEEF);
    step();
    we = 2'b00;
    wdata = '0;
    #1;
    chk("basic_stored", rdata[31:0], 32'hDEADBEEF);
  endtask

  task automatic test_conflict();
    idle_inputs();
    we    = 2'b11;
    waddr = {5'd7, 5'd7};
    wdata = {32'h22222222, 32'h11111111};
    raddr = {5'd7, 5'd7};
    #1;
    chk("conflict_byp0", rdata[31:0], 32'h22222222);
    chk("conflict_byp1", rdata[63:32], 32'h22222222);
    step();
    we = 2'b00;
    wdata = '0;
    #1;
    chk("conflict_stored0", rdata[31:0], 32'h22222222);
    chk("conflict_stored1", rdata[63:32], 32'h22222222);
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    we    = 2'b10;
    waddr = {5'd0, 5'd0};
    wdata = {32'hFFFFFFFF, 32'h0};
    raddr = {5'd0, 5'd0};
    #1;
    chk("zero_same0", rdata[31:0], 32'h0);
    chk("zero_same1", rdata[63:32], 32'h0);
    step();
    we = 2'b00;
    #1;
    chk("zero_after0", rdata[31:0], 32'h0);
    chk("zero_after1", rdata[63:32], 32'h0);
  endtask

  task automatic test_re_gating();
    idle_inputs();
    we          = 2'b01;
    waddr[4:0]  = 5'd9;
    wdata[31:0] = 32'h00000055;
    step();
    we    = 2'b00;
    re    = 2'b01;
    raddr = {5'd9, 5'd9};
    #1;
    chk("re_enabled", rdata[31:0], 32'h00000055);
    chk("re_gated", rdata[63:32], 32'h0);
    // Gating must also win over a live bypass hit.
    we          = 2'b01;
    wdata[31:0] = 32'h00000077;
    #1;
    chk("re_gated_byp", rdata[63:32], 32'h0);
    chk("re_enabled_byp", rdata[31:0], 32'h00000077);
    step();
    we = 2'b00;
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    we    = 2'b11;
    waddr = {5'd13, 5'd12};
    wdata = {32'hB0B0B0B0, 32'hA0A0A0A0};
    raddr = {5'd12, 5'd13};
    #1;
    chk("b2b_byp_r13", rdata[31:0], 32'hB0B0B0B0);
    chk("b2b_byp_r12", rdata[63:32], 32'hA0A0A0A0);
    step();
    waddr = {5'd12, 5'd14};
    wdata = {32'h12121212, 32'h14141414};
    raddr = {5'd13, 5'd14};
    #1;
    chk("b2b_stored_r13", rdata[63:32], 32'hB0B0B0B0);
    chk("b2b_byp_r14", rdata[31:0], 32'h14141414);
    step();
    we    = 2'b00;
    raddr = {5'd12, 5'd14};
    #1;
    chk("b2b_over_r12", rdata[63:32], 32'h12121212);
    chk("b2b_stored_r14", rdata[31:0], 32'h14141414);
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    we           = 2'b01;
    waddr[4:0]   = 5'd9;
    wdata[31:0]  = 32'h00001234;
    step();
    we    = 2'b00;
    raddr = {5'd9, 5'd9};
    #1;
    chk("mid_pre_r9", rdata[31:0], 32'h00001234);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_async_ready", {31'd0, ready}, 32'd0);
    chk("mid_async_rdata", rdata[31:0], 32'h0);
    step();
    rst   = 1'b1;
    we    = 2'b11;
    waddr = {5'd9, 5'd9};
    wdata = {32'hBEEFBEEF, 32'h0000BEEF};
    for (int i = 0; i < 32; i++) begin
      #1;
      if (i == 0 || i == 31) begin
        chk("mid_init_ready", {31'd0, ready}, 32'd0);
        chk("mid_init_rdata", rdata[63:32], 32'h0);
      end
      step();
    end
    chk("mid_ready_back", {31'd0, ready}, 32'd1);
    we = 2'b00;
    #1;
    chk("mid_r9_cleared", rdata[31:0], 32'h0);
    chk("mid_r9_cleared1", rdata[63:32], 32'h0);
  endtask

`ifdef REGFILE_PROBE_EN
  task automatic test_probe();
    idle_inputs();
    we    = 2'b11;
    waddr = {5'd19, 5'd4};
    wdata = {32'h0000000B, 32'h0000000A};
    #1;
    chk("probe_a_no_bypass", probe_a, 32'h0);
    chk("probe_b_no_bypass", probe_b, 32'h0);
    step();
    we = 2'b00;
    #1;
    chk("probe_a", probe_a, 32'h0000000A);
    chk("probe_b", probe_b, 32'h0000000B);
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_conflict();
    test_zero_reg();
    test_re_gating();
    test_back_to_back();
`ifdef REGFILE_PROBE_EN
    test_probe();
`endif
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_mp

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-issue MIPS32 register file, for dual-issue and wider cores.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with write-to-read bypass and deterministic write-port priority.
- A post-reset sweep FSM clears one entry per cycle, so deep files map to RAM-style storage without per-entry reset.
- Sits between ID (reads) and WB (writes) in the core pipeline.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports.
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero and writes to it are dropped.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- we  in  NUM_WR  per-port write enable.
- waddr  in  NUM_WR*ADDR_W  packed write addresses, port k at [k*ADDR_W +: ADDR_W].
- wdata  in  NUM_WR*DATA_W  packed write data.
- re  in  NUM_RD  per-port read enable.
- raddr  in  NUM_RD*ADDR_W  packed read addresses.
- rdata  out  NUM_RD*DATA_W  packed read data, combinational.
- ready  out  1  high once the init sweep is complete.

Behaviour:
- Reset: rst low asynchronously forces FSM to INIT, sweep counter to 0, ready to 0. Storage entries are not reset.
- INIT state:
  - Each cycle writes zero to entry[cnt], then cnt increments.
  - Transition to RUN on the cycle after cnt == 2**ADDR_W-1 is cleared; ready goes high that cycle.
  - Latency from rst deassertion to ready=1 is 2**ADDR_W cycles.
- INIT, ports: all we ignored; all rdata = 0.
- RUN state: stays in RUN until the next reset. rst assertion mid-operation aborts everything and restarts INIT from entry 0.
- Write:
  - On the clk rising edge, each port with we[k]=1 writes wdata[k] into entry waddr[k].
  - Same-address conflict: the highest-index enabled port wins; lower ports are dropped for that entry.
  - ZERO_REG=1 and waddr=0: the write is discarded.
- Read (combinational), per port j, in priority order:
  1. ready=0, re[j]=0, or (ZERO_REG=1 and raddr[j]=0): rdata[j] = 0.
  2. Any enabled write port has waddr == raddr[j]: rdata[j] = wdata of the highest-index such port (bypass).
  3. Otherwise: rdata[j] = entry[raddr[j]].
- Read ports are fully independent; any number may address the same entry.
- All widths are exact; no sign/zero extension is performed.

Optional Feature:
- Macro: REGFILE_PROBE_EN.
- Defined:
  - Adds output probe_a (DATA_W) and probe_b (DATA_W), driven combinationally from entry[PROBE_A_IDX] and entry[PROBE_B_IDX].
  - Adds parameters PROBE_A_IDX (default 4) and PROBE_B_IDX (default 19).
  - Probes show stored values with no bypass, and are 0 while ready=0.
  - Used for board display and debug.
- Undefined: ports and parameters are absent; no probe logic is generated.

Decomposition:
- Shared package/defines:
  - default DATA_W/ADDR_W, matching existing RegBus/RegAddrBus widths;
  - FSM state encoding (ST_INIT=1'b0, ST_RUN=1'b1);
  - ZeroWord constant.
- Sub-module regfile_bypass_sel: one instance per read port. Takes the packed we/waddr/wdata plus a raddr; returns hit and selected data using highest-index priority.
- Storage and the sweep FSM stay in the top module.

Test Plan:
- Reset/init: default params; deassert rst at t0.
  - ready=0 and rdata=0 for cycles 0..31; ready=1 at cycle 32.
  - Reading r5 afterwards returns 0x00000000.
- Basic write/read: we=2'b01, waddr0=3, wdata0=0xDEADBEEF.
  - Same cycle: read port 0 on r3 returns 0xDEADBEEF via bypass.
  - Next cycle (we=0): read returns 0xDEADBEEF from storage.
- Write conflict: both ports write r7 (port0 0x11111111, port1 0x22222222).
  - Bypass read = 0x22222222; stored value = 0x22222222.
- Zero register: write r0=0xFFFFFFFF on port1.
  - All reads of r0 return 0 in the same cycle and after.
- Mid-operation reset: write r9=0x1234 in RUN, then pulse rst low for 1 cycle.
  - ready drops immediately (asynchronously); writes during INIT are ignored.
  - After 32 cycles ready=1 and r9 reads 0.
- re gating / probes: re[1]=0 with raddr1=9 holding 0x55 → rdata1=0.
  - With REGFILE_PROBE_EN, writing r4=0xA and r19=0xB → probe_a=0xA, probe_b=0xB one cycle later.
